// File: rtl/param_sync_fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared read-mode constants and sizing helper for param_sync_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int FIFO_REG  = 0;
  localparam int FIFO_FWFT = 1;

  // Bits needed to address 'value' distinct entries (0 for a single entry).
  function automatic int fifo_clog2(input int value);
    return (value <= 1) ? 0 : $clog2(value);
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_sync_fifo_if.sv
// ============================================================================
// Module   : param_sync_fifo_if
// Brief    : Producer/consumer handshake and status bundle for param_sync_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_sync_fifo_if #(
  parameter int width    = 8,
  parameter int addrbits = 4
);

  logic [width-1:0]  dataIn;
  logic              insert;
  logic              remove;
  logic              flush;
  logic [width-1:0]  dataOut;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [addrbits:0] count;
  logic              overflow;
  logic              underflow;

  modport master (
    output dataIn, insert, remove, flush,
    input  dataOut, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  dataIn, insert, remove, flush,
    output dataOut, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/param_sync_fifo_ram.sv
// ============================================================================
// Module   : fifo_ram
// Brief    : width x depth storage, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram #(
  parameter int width    = 8,
  parameter int depth    = 16,
  parameter int addrbits = 4
) (
  input  wire logic                clk,
  input  wire logic                i_wr_en,
  input  wire logic [addrbits-1:0] i_wr_addr,
  input  wire logic [width-1:0]    i_wr_data,
  input  wire logic [addrbits-1:0] i_rd_addr,
  output logic      [width-1:0]    o_rd_data
);

  logic [width-1:0] r_mem [0:depth-1];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/param_sync_fifo.sv
// ============================================================================
// Module   : param_sync_fifo
// Brief    : Single-clock FIFO, arbitrary depth, thresholds, sticky errors,
//            registered or first-word-fall-through read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int width     = 8,
  parameter int addrbits  = 4,
  parameter int depth     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FIFO_REG
) (
  input wire logic         clk_in,
  input wire logic         rst,
  param_sync_fifo_if.slave bus
);

  localparam int                CW          = addrbits + 1;
  localparam logic [CW-1:0]     c_depth     = CW'(depth);
  localparam logic [CW-1:0]     c_af_thresh = CW'(AF_THRESH);
  localparam logic [CW-1:0]     c_ae_thresh = CW'(AE_THRESH);
  localparam logic [addrbits-1:0] c_last_addr = addrbits'(depth - 1);

  generate
    if (fifo_clog2(depth) > addrbits) begin : g_err_depth_fit
      $error("param_sync_fifo: depth %0d needs more than addrbits=%0d", depth, addrbits);
    end
    if (depth < 2) begin : g_err_depth_min
      $error("param_sync_fifo: depth %0d below minimum of 2", depth);
    end
    if (AF_THRESH < 1 || AF_THRESH > depth) begin : g_err_af
      $error("param_sync_fifo: AF_THRESH %0d outside 1..%0d", AF_THRESH, depth);
    end
    if (AE_THRESH < 0 || AE_THRESH > depth - 1) begin : g_err_ae
      $error("param_sync_fifo: AE_THRESH %0d outside 0..%0d", AE_THRESH, depth - 1);
    end
  endgenerate

  logic [addrbits-1:0] r_wraddr;
  logic [addrbits-1:0] r_rdaddr;
  logic [CW-1:0]       r_count;
  logic                r_overflow;
  logic                r_underflow;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic [width-1:0]    w_rd_data;

  // Flags come from the registered count only, never from this cycle's requests.
  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  assign w_wr_ok = bus.insert & ~w_full  & ~bus.flush;
  assign w_rd_ok = bus.remove & ~w_empty & ~bus.flush;

  function automatic logic [addrbits-1:0] next_addr(input logic [addrbits-1:0] addr);
    return (addr == c_last_addr) ? '0 : addr + addrbits'(1);
  endfunction

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_wraddr    <= '0;
      r_rdaddr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wraddr    <= '0;
      r_rdaddr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wraddr <= next_addr(r_wraddr);
      end
      if (w_rd_ok) begin
        r_rdaddr <= next_addr(r_rdaddr);
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.insert & w_full) begin
        r_overflow <= 1'b1;
      end
      if (bus.remove & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  fifo_ram #(
    .width    (width),
    .depth    (depth),
    .addrbits (addrbits)
  ) u_ram (
    .clk       (clk_in),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (r_wraddr),
    .i_wr_data (bus.dataIn),
    .i_rd_addr (r_rdaddr),
    .o_rd_data (w_rd_data)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      assign bus.dataOut = w_empty ? '0 : w_rd_data;
    end else begin : g_reg
      logic [width-1:0] r_dataout;

      always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
          r_dataout <= '0;
        end else if (bus.flush) begin
          r_dataout <= '0;
        end else if (w_rd_ok) begin
          r_dataout <= w_rd_data;
        end
      end

      assign bus.dataOut = r_dataout;
    end
  endgenerate

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= c_af_thresh);
  assign bus.almost_empty = (r_count <= c_ae_thresh);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
// ============================================================================
// Module   : tb_param_sync_fifo
// Brief    : Directed bench driving a registered-read and an FWFT instance in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_sync_fifo;
  import fifo_pkg::*;

  localparam int W  = 8;
  localparam int AB = 3;
  localparam int D  = 6;
  localparam int AF = 5;
  localparam int AE = 1;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       insert;
  logic       remove;
  logic       flush;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] q[$];
  logic [7:0] exp_byte;

  param_sync_fifo_if #(.width(W), .addrbits(AB)) if_r ();
  param_sync_fifo_if #(.width(W), .addrbits(AB)) if_f ();

  assign if_r.dataIn = din;
  assign if_r.insert = insert;
  assign if_r.remove = remove;
  assign if_r.flush  = flush;
  assign if_f.dataIn = din;
  assign if_f.insert = insert;
  assign if_f.remove = remove;
  assign if_f.flush  = flush;

  param_sync_fifo #(
    .width(W), .addrbits(AB), .depth(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(FIFO_REG)
  ) dut_reg (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (if_r)
  );

  param_sync_fifo #(
    .width(W), .addrbits(AB), .depth(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(FIFO_FWFT)
  ) dut_fwft (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (if_f)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input int n);
    check({tag, ".count_r"}, 32'(if_r.count), 32'(n));
    check({tag, ".count_f"}, 32'(if_f.count), 32'(n));
    check({tag, ".empty_r"}, 32'(if_r.empty), 32'(n == 0));
    check({tag, ".empty_f"}, 32'(if_f.empty), 32'(n == 0));
    check({tag, ".full"},    32'(if_r.full), 32'(n == D));
    check({tag, ".afull"},   32'(if_r.almost_full), 32'(n >= AF));
    check({tag, ".aempty"},  32'(if_r.almost_empty), 32'(n <= AE));
  endtask

  task automatic check_err(input string tag, input logic ov, input logic un);
    check({tag, ".ovf_r"}, 32'(if_r.overflow), 32'(ov));
    check({tag, ".ovf_f"}, 32'(if_f.overflow), 32'(ov));
    check({tag, ".udf_r"}, 32'(if_r.underflow), 32'(un));
    check({tag, ".udf_f"}, 32'(if_f.underflow), 32'(un));
  endtask

  task automatic check_dr(input string tag, input logic [7:0] v);
    check({tag, ".dout_r"}, 32'(if_r.dataOut), 32'(v));
  endtask

  task automatic check_df(input string tag, input logic [7:0] v);
    check({tag, ".dout_f"}, 32'(if_f.dataOut), 32'(v));
  endtask

  initial begin
    rst = 1'b1; din = '0; insert = 1'b0; remove = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    #10;
    check_flags("reset", 0);
    check_err("reset", 1'b0, 1'b0);
    check_dr("reset", 8'h00);
    check_df("reset", 8'h00);
    rst = 1'b1;

    // single write then read
    din = 8'hA5; insert = 1'b1; tick(); insert = 1'b0;
    check_flags("t1_wr", 1);
    check_dr("t1_wr", 8'h00);
    check_df("t1_wr", 8'hA5);
    remove = 1'b1; tick(); remove = 1'b0;
    check_flags("t1_rd", 0);
    check_dr("t1_rd", 8'hA5);
    check_df("t1_rd", 8'h00);

    // fill to full, overflow, drain across the address wrap
    for (int i = 1; i <= D; i++) begin
      din = 8'(i); insert = 1'b1; tick();
      check_flags($sformatf("t2_fill%0d", i), i);
    end
    check_df("t2_full", 8'h01);
    din = 8'h07; tick(); insert = 1'b0;
    check_flags("t2_ovf", D);
    check_err("t2_ovf", 1'b1, 1'b0);
    for (int i = 1; i <= D; i++) begin
      check_df($sformatf("t2_head%0d", i), 8'(i));
      remove = 1'b1; tick();
      check_dr($sformatf("t2_drain%0d", i), 8'(i));
      check_flags($sformatf("t2_drain%0d", i), D - i);
    end
    remove = 1'b0;
    check_df("t2_empty", 8'h00);

    // steady simultaneous insert/remove at count 3
    for (int i = 0; i < 3; i++) begin
      din = 8'h10 + 8'(i); insert = 1'b1; tick(); q.push_back(din);
    end
    insert = 1'b0;
    check_flags("t3_pre", 3);
    for (int k = 0; k < 10; k++) begin
      exp_byte = q.pop_front();
      check_df($sformatf("t3_rw%0d", k), exp_byte);
      din = 8'h20 + 8'(k); insert = 1'b1; remove = 1'b1; tick();
      q.push_back(din);
      check_dr($sformatf("t3_rw%0d", k), exp_byte);
      check_flags($sformatf("t3_rw%0d", k), 3);
    end
    insert = 1'b0;
    while (q.size() > 0) begin
      exp_byte = q.pop_front();
      check_df("t3_drain", exp_byte);
      remove = 1'b1; tick();
      check_dr("t3_drain", exp_byte);
    end
    remove = 1'b0;
    check_flags("t3_done", 0);

    // underflow, then insert+remove on an empty FIFO
    remove = 1'b1; tick();
    check_flags("t4_udf", 0);
    check_err("t4_udf", 1'b1, 1'b1);
    check_dr("t4_udf", exp_byte);
    din = 8'h55; insert = 1'b1; tick(); insert = 1'b0; remove = 1'b0;
    check_flags("t4_rw", 1);
    check_dr("t4_rw", exp_byte);
    check_df("t4_rw", 8'h55);

    // flush beats a concurrent insert
    for (int i = 0; i < 3; i++) begin
      din = 8'h60 + 8'(i); insert = 1'b1; tick();
    end
    check_flags("t5_pre", 4);
    check_err("t5_pre", 1'b1, 1'b1);
    din = 8'h77; flush = 1'b1; tick(); insert = 1'b0; flush = 1'b0;
    check_flags("t5_flush", 0);
    check_err("t5_flush", 1'b0, 1'b0);
    check_dr("t5_flush", 8'h00);
    check_df("t5_flush", 8'h00);
    din = 8'h88; insert = 1'b1; tick(); insert = 1'b0;
    check_flags("t5_wr", 1);
    check_df("t5_wr", 8'h88);
    remove = 1'b1; tick(); remove = 1'b0;
    check_dr("t5_rd", 8'h88);
    check_flags("t5_rd", 0);

    // asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      din = 8'h91 + 8'(i); insert = 1'b1; tick();
    end
    insert = 1'b0;
    check_flags("t6_pre", 3);
    #2 rst = 1'b0;
    #1;
    check_flags("t6_rst", 0);
    check_dr("t6_rst", 8'h00);
    check_df("t6_rst", 8'h00);
    tick();
    rst = 1'b1;
    din = 8'hC3; insert = 1'b1; tick(); insert = 1'b0;
    check_flags("t6_wr", 1);
    check_df("t6_wr", 8'hC3);
    remove = 1'b1; tick(); remove = 1'b0;
    check_dr("t6_rd", 8'hC3);

    // boundaries: simultaneous ops at depth-1, insert+remove while full, at count 1
    for (int i = 0; i < D - 1; i++) begin
      din = 8'hD0 + 8'(i); insert = 1'b1; tick(); q.push_back(din);
    end
    check_flags("t7_pre", D - 1);
    exp_byte = q.pop_front();
    din = 8'hD5; remove = 1'b1; tick(); q.push_back(din);
    check_dr("t7_rw5", exp_byte);
    check_flags("t7_rw5", D - 1);
    remove = 1'b0; din = 8'hD6; tick(); q.push_back(din);
    check_flags("t7_full", D);
    exp_byte = q.pop_front();
    din = 8'hD7; remove = 1'b1; tick(); insert = 1'b0;
    check_dr("t7_fullrw", exp_byte);
    check_flags("t7_fullrw", D - 1);
    check_err("t7_fullrw", 1'b1, 1'b0);
    while (q.size() > 1) begin
      exp_byte = q.pop_front();
      tick();
      check_dr("t7_drain", exp_byte);
    end
    check_flags("t7_one", 1);
    exp_byte = q.pop_front();
    check_df("t7_rw1", exp_byte);
    din = 8'hE0; insert = 1'b1; tick(); insert = 1'b0; remove = 1'b0;
    check_dr("t7_rw1", exp_byte);
    check_df("t7_rw1_next", 8'hE0);
    check_flags("t7_rw1", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
